// File: rtl/prio_seg_pkg.sv
// rtl/prio_seg_pkg.sv - shared types, glyphs and helpers for the priority encoder display
package prio_seg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Active-high segment patterns, bit order {A,B,C,D,E,F,G}
  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b0011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1110011;

  // Smallest r with 2**r >= n
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/seg7_bcd_dec.sv
// rtl/seg7_bcd_dec.sv - one BCD digit to active-low seven-segment pattern with blanking
module seg7_bcd_dec
  import prio_seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] glyph;

  // Digit to active-high glyph; codes above 9 never occur and fall back to 0
  always_comb begin
    glyph = GLYPH_0;
    case (bcd)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = GLYPH_0;
    endcase
  end

  assign seg = blank ? 7'h7F : ~glyph;

endmodule

// File: rtl/prio_enc_seg.sv
// rtl/prio_enc_seg.sv - registered priority encoder with double-dabble decimal seven-segment output
module prio_enc_seg
  import prio_seg_pkg::*;
#(
  parameter  int W      = 16,
  parameter  int DIGITS = 2,
  localparam int IW     = clog2(W),
  localparam int VW     = clog2(W + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  start,
  input  logic [W-1:0]          x,
  output logic [IW-1:0]         y,
  output logic                  z,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = clog2(VW + 1);

  if (pow10(DIGITS) <= W) begin : g_digits_check
    $error("prio_enc_seg: DIGITS too small to display W");
  end

  state_t              state_q;
  state_t              state_d;
  logic                load;
  logic                finish;
  logic                last;
  logic [IW-1:0]       idx;
  logic                any;
  logic [VW-1:0]       val;
  logic [VW-1:0]       sr_q;
  logic [BW-1:0]       bcd_q;
  logic [BW-1:0]       adj;
  logic [BW-1:0]       bcd_d;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       y_pend;
  logic                z_pend;
  logic [DIGITS-1:0]   blank;
  logic                upper_nz;
  logic [7*DIGITS-1:0] dec_seg;

  // Highest set bit of x; later (higher) indices override earlier ones
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

  assign val  = any ? (VW'(idx) + VW'(1)) : '0;
  assign last = (cnt_q == CW'(VW - 1));
  assign busy = (state_q == CONV);

  // Next state and strobes; en low forces IDLE and suppresses load/finish
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (last) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
    if (!en) begin
      state_d = IDLE;
      load    = 1'b0;
      finish  = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next value bit
  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    bcd_d = BW'({adj, sr_q[VW-1]});
  end

  // Capture on start, then shift once per CONV cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      y_pend <= '0;
      z_pend <= 1'b0;
    end else if (load) begin
      sr_q   <= val;
      bcd_q  <= '0;
      cnt_q  <= '0;
      y_pend <= idx;
      z_pend <= any;
    end else if (en && state_q == CONV) begin
      sr_q  <= sr_q << 1;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Leading-zero blanking on the final BCD value; digit 0 always lit
  always_comb begin
    blank    = '0;
    upper_nz = 1'b0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      upper_nz = upper_nz | (bcd_d[4*d +: 4] != 4'd0);
      blank[d] = ~upper_nz;
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    seg7_bcd_dec u_dec (
      .bcd   (bcd_d[4*d +: 4]),
      .blank (blank[d]),
      .seg   (dec_seg[7*d +: 7])
    );
  end

  // Result registers update only on the last shift; en low blanks them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y    <= '0;
      z    <= 1'b0;
      seg  <= '1;
      done <= 1'b0;
    end else if (!en) begin
      y    <= '0;
      z    <= 1'b0;
      seg  <= '1;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        y   <= y_pend;
        z   <= z_pend;
        seg <= dec_seg;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_seg.sv
// tb/tb_prio_enc_seg.sv - scoreboard bench for prio_enc_seg (W=16/DIGITS=2 and W=8/DIGITS=1)
module tb_prio_enc_seg;

  localparam int LAT16 = 5;
  localparam int LAT8  = 4;

  typedef struct {
    logic [7:0]  y;
    logic        z;
    logic [13:0] seg;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, start;
  logic [15:0] x;
  logic [3:0]  y;
  logic        z;
  logic [13:0] seg;
  logic        busy, done;
  logic        en8, start8;
  logic [7:0]  x8;
  logic [2:0]  y8;
  logic        z8;
  logic [6:0]  seg8;
  logic        busy8, done8;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done8_cnt = 0;
  exp_t q16[$];
  exp_t q8[$];
  exp_t e16, e8;

  logic [6:0] glyph [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b0011111, 7'b1110000, 7'b1111111, 7'b1110011};

  prio_enc_seg #(.W(16), .DIGITS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .x(x),
    .y(y), .z(z), .seg(seg), .busy(busy), .done(done)
  );

  prio_enc_seg #(.W(8), .DIGITS(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .start(start8), .x(x8),
    .y(y8), .z(z8), .seg(seg8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: highest index, V = index+1, decimal digits by division, blank leading zeros
  function automatic exp_t model(input logic [31:0] v, input int w, input int ndig, input int c);
    exp_t r;
    int   idx;
    int   val;
    int   p;
    int   dig;
    idx = -1;
    for (int i = w - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = i;
        break;
      end
    end
    val   = idx + 1;
    r.y   = (idx < 0) ? 8'd0 : 8'(idx);
    r.z   = (idx >= 0);
    r.seg = '1;
    p     = 1;
    for (int d = 0; d < ndig; d++) begin
      dig = (val / p) % 10;
      if (d == 0 || val >= p) r.seg[7*d +: 7] = ~glyph[dig];
      p = p * 10;
    end
    r.cyc = c;
    return r;
  endfunction

  // Monitor for the 16-bit instance
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done16: got done=1 expected no pending result");
      end else begin
        e16 = q16.pop_front();
        check("y16", 32'(y), 32'(e16.y));
        check("z16", 32'(z), 32'(e16.z));
        check("seg16", 32'(seg), 32'(e16.seg));
        check("latency16", cyc, e16.cyc);
        check("busy_at_done16", 32'(busy), 32'd0);
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (rst_n && done8) begin
      done8_cnt++;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done8: got done=1 expected no pending result");
      end else begin
        e8 = q8.pop_front();
        check("y8", 32'(y8), 32'(e8.y));
        check("z8", 32'(z8), 32'(e8.z));
        check("seg8", 32'(seg8), 32'(e8.seg[6:0]));
        check("latency8", cyc, e8.cyc);
      end
    end
  end

  task automatic issue(input logic [15:0] v, input bit poke);
    x     = v;
    start = 1'b1;
    q16.push_back(model(32'(v), 16, 2, cyc + 1 + LAT16));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start16", 32'(busy), 32'd1);
    if (poke) begin
      x     = 16'hFFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done16_timeout: got no done expected one within 20 cycles");
      q16.delete();
    end
  endtask

  task automatic issue8(input logic [7:0] v);
    int n;
    x8     = v;
    start8 = 1'b1;
    q8.push_back(model(32'(v), 8, 1, cyc + 1 + LAT8));
    @(negedge clk);
    start8 = 1'b0;
    check("busy_after_start8", 32'(busy8), 32'd1);
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done8) begin
      checks++;
      errors++;
      $display("FAIL done8_timeout: got no done expected one within 20 cycles");
      q8.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int          saved;
    int          sh;
    logic [31:0] rv;
    rst_n = 1'b0; en = 1'b1; start = 1'b0; x = '0;
    en8 = 1'b1; start8 = 1'b0; x8 = '0;
    repeat (2) @(negedge clk);
    check("reset_y", 32'(y), 32'd0);
    check("reset_z", 32'(z), 32'd0);
    check("reset_seg", 32'(seg), 32'h3FFF);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_seg8", 32'(seg8), 32'h7F);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h0000, 1'b0); wait_done(); @(negedge clk);
    issue(16'h8001, 1'b0); wait_done(); @(negedge clk);
    issue(16'h0010, 1'b1); wait_done();
    issue(16'h0200, 1'b0); wait_done(); @(negedge clk);

    // Asynchronous reset two cycles into a conversion
    saved = done_cnt;
    x = 16'h4000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_seg", 32'(seg), 32'h3FFF);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_y", 32'(y), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_mid_no_done", done_cnt, saved);

    issue(16'h8001, 1'b0); wait_done(); @(negedge clk);

    // en dropped at the third CONV edge
    saved = done_cnt;
    x = 16'h0100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("en_abort_seg", 32'(seg), 32'h3FFF);
    check("en_abort_busy", 32'(busy), 32'd0);
    check("en_abort_y", 32'(y), 32'd0);
    check("en_abort_z", 32'(z), 32'd0);
    check("en_abort_done", 32'(done), 32'd0);
    en = 1'b1;
    repeat (8) @(negedge clk);
    check("en_abort_no_done", done_cnt, saved);

    // Random requests, sometimes back-to-back in the done cycle
    for (int k = 0; k < 40; k++) begin
      sh = $urandom_range(0, 16);
      rv = $urandom;
      if (sh < 16) rv = rv & ((32'h1 << sh) - 32'h1);
      issue(rv[15:0], ($urandom_range(0, 4) == 0));
      wait_done();
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    @(negedge clk);

    // Narrow variant
    issue8(8'h80);
    issue8(8'h01);
    issue8(8'h00);
    issue8(8'h0C);
    saved = done8_cnt;
    x8 = 8'h40; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en8 = 1'b0;
    @(negedge clk);
    check("en8_abort_seg", 32'(seg8), 32'h7F);
    check("en8_abort_busy", 32'(busy8), 32'd0);
    en8 = 1'b1;
    repeat (8) @(negedge clk);
    check("en8_abort_no_done", done8_cnt, saved);
    for (int k = 0; k < 6; k++) issue8(8'($urandom));

    check("q16_drained", q16.size(), 0);
    check("q8_drained", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
